// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB).
// Sequences one shared memory port and one ALU across instruction phases.
// All strobes are combinational from the current state, the latched
// opcode/funct, zero and mem_ready. They are forced low while reset is held.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       ir_op,
    input  logic [5:0]       ir_funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_b,
    output logic [4:0]       aluop,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLT = 5'd4;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    state_e           state_q, state_d;
    logic [5:0]       op_q, funct_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    // Transition flags raised by the sequencer for the bookkeeping registers
    logic             retire;
    logic             set_illegal;

    // Instruction classification from the latched opcode/funct
    logic       is_r, is_addi, is_lw, is_sw, is_beq, is_j, r_ok, legal;
    logic [4:0] r_aluop;

    // Decode the latched instruction into class flags and the R-type ALU op
    always_comb begin
        is_r    = (op_q == OP_RTYPE);
        is_addi = (op_q == OP_ADDI);
        is_lw   = (op_q == OP_LW);
        is_sw   = (op_q == OP_SW);
        is_beq  = (op_q == OP_BEQ);
        is_j    = (op_q == OP_J);
        r_ok    = 1'b1;
        r_aluop = ALU_ADD;
        case (funct_q)
            FN_ADD:  r_aluop = ALU_ADD;
            FN_SUB:  r_aluop = ALU_SUB;
            FN_AND:  r_aluop = ALU_AND;
            FN_OR:   r_aluop = ALU_OR;
            FN_SLT:  r_aluop = ALU_SLT;
            default: r_ok    = 1'b0;
        endcase
        legal = (is_r && r_ok) || is_addi || is_lw || is_sw || is_beq || is_j;
    end

    // Next-state and strobe generation; every output defaults to inactive
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SEQ;
        ir_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_b   = 1'b0;
        aluop       = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_j) begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (!legal) begin
                    // PC already advanced in FETCH; just drop the instruction
                    set_illegal = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_r) begin
                    aluop   = r_aluop;
                    state_d = S_WB;
                end else if (is_beq) begin
                    aluop    = ALU_SUB;
                    pc_write = zero;
                    pc_src   = PC_BRANCH;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    // addi / lw / sw all compute base + imm
                    aluop     = ALU_ADD;
                    alu_src_b = 1'b1;
                    state_d   = (is_addi) ? S_WB : S_MEM;
                end
            end
            S_MEM: begin
                iord      = 1'b1;
                mem_read  = is_lw;
                mem_write = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_r;
                mem_to_reg = is_lw;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                // Unreachable encodings recover to FETCH with no strobes
                state_d = S_FETCH;
            end
        endcase

        // Held reset kills every strobe, including the FETCH read
        if (!reset) begin
            state_d     = S_FETCH;
            retire      = 1'b0;
            set_illegal = 1'b0;
            pc_write    = 1'b0;
            pc_src      = PC_SEQ;
            ir_write    = 1'b0;
            iord        = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            alu_src_b   = 1'b0;
            aluop       = ALU_ADD;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Instruction latch, loaded on the IR write strobe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q    <= 6'd0;
            funct_q <= 6'd0;
        end else if (ir_write) begin
            op_q    <= ir_op;
            funct_q <= ir_funct;
        end
    end

    // Sticky illegal flag and retired-instruction counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            if (set_illegal) illegal_q <= 1'b1;
            if (retire)      retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl. The stimulus side expands each
// instruction into its phase sequence, pushes the expected outputs of every
// cycle, and a negedge monitor pops and compares.
module tb_mc_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  ir_op = '0, ir_funct = '0;
    logic        zero = 1'b0, mem_ready = 1'b0;
    logic        pc_write, ir_write, iord, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_b, illegal;
    logic [1:0]  pc_src;
    logic [4:0]  aluop;
    logic [2:0]  state;
    logic [31:0] retired;

    mc_ctrl #(.CNT_W(32)) dut (
        .clock(clock), .reset(reset), .ir_op(ir_op), .ir_funct(ir_funct),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_b(alu_src_b), .aluop(aluop), .state(state), .illegal(illegal),
        .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  st;
        logic        pcw;
        logic [1:0]  pcs;
        logic        irw, iord, mr, mw, rw, rd, m2r, asb;
        logic [4:0]  aop;
        logic        ill;
        logic [31:0] ret;
    } obs_t;

    typedef enum {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_e;

    obs_t  expq[$];
    string nameq[$];
    int    n_chk = 0, n_pass = 0;
    logic [31:0] exp_ret = '0;
    logic        exp_ill = 1'b0;

    obs_t act;
    assign act = {state, pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                  reg_write, reg_dst, mem_to_reg, alu_src_b, aluop, illegal, retired};

    // Monitor: one expected record per clock, compared mid-cycle
    always @(negedge clock) begin
        obs_t  e;
        string nm;
        if (expq.size() > 0) begin
            e  = expq.pop_front();
            nm = nameq.pop_front();
            n_chk++;
            if (act === e) n_pass++;
            else $display("FAIL %s @%0t: got st=%0d %h want st=%0d %h",
                          nm, $time, act.st, act, e.st, e);
        end
    end

    function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) ? K_R : K_ILL;
            6'h08:   return K_ADDI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h02:   return K_J;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [4:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 5'd1;
            6'h24:   return 5'd2;
            6'h25:   return 5'd3;
            6'h2A:   return 5'd4;
            default: return 5'd0;
        endcase
    endfunction

    function automatic obs_t base(input logic [2:0] s);
        obs_t o = '0;
        o.st  = s;
        o.ill = exp_ill;
        o.ret = exp_ret;
        return o;
    endfunction

    // Drive one cycle's inputs just after the edge and queue its expectation
    task automatic step(input obs_t e, input string nm, input logic rst,
                        input logic rdy, input logic zr,
                        input logic [5:0] op, input logic [5:0] fn);
        @(posedge clock);
        #1;
        reset = rst; mem_ready = rdy; zero = zr; ir_op = op; ir_funct = fn;
        expq.push_back(e);
        nameq.push_back(nm);
    endtask

    task automatic do_reset(input int n);
        exp_ret = '0;
        exp_ill = 1'b0;
        for (int i = 0; i < n; i++)
            step(base(3'd0), "reset", 1'b0, 1'($urandom), 1'($urandom),
                 6'($urandom), 6'($urandom));
    endtask

    // Expand one instruction into cycles. abort_ms >= 0 stops inside the MEM
    // stall after that many stall cycles, leaving the instruction unretired.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                             input int fs, input int ms, input int abort_ms);
        kind_e k = classify(op, fn);
        obs_t  o;
        for (int i = 0; i < fs; i++) begin
            o = base(3'd0); o.mr = 1'b1;
            step(o, "fetch_wait", 1'b1, 1'b0, 1'($urandom), op, fn);
        end
        o = base(3'd0); o.mr = 1'b1; o.irw = 1'b1; o.pcw = 1'b1;
        step(o, "fetch", 1'b1, 1'b1, 1'($urandom), op, fn);

        o = base(3'd1);
        if (k == K_J) begin o.pcw = 1'b1; o.pcs = 2'd2; end
        step(o, "decode", 1'b1, 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom));
        if (k == K_J)   begin exp_ret++; return; end
        if (k == K_ILL) begin exp_ill = 1'b1; return; end

        o = base(3'd2);
        case (k)
            K_R:   o.aop = r_alu(fn);
            K_BEQ: begin o.aop = 5'd1; o.pcw = zr; o.pcs = 2'd1; end
            default: begin o.aop = 5'd0; o.asb = 1'b1; end
        endcase
        step(o, "exec", 1'b1, 1'($urandom), zr, 6'($urandom), 6'($urandom));
        if (k == K_BEQ) begin exp_ret++; return; end

        if (k == K_LW || k == K_SW) begin
            o = base(3'd3); o.iord = 1'b1; o.mr = (k == K_LW); o.mw = (k == K_SW);
            for (int i = 0; i < ms; i++) begin
                if (i == abort_ms) return;
                step(o, "mem_wait", 1'b1, 1'b0, 1'($urandom), 6'($urandom), 6'($urandom));
            end
            if (ms == abort_ms) return;
            step(o, "mem", 1'b1, 1'b1, 1'($urandom), 6'($urandom), 6'($urandom));
            if (k == K_SW) begin exp_ret++; return; end
        end

        o = base(3'd4); o.rw = 1'b1; o.rd = (k == K_R); o.m2r = (k == K_LW);
        step(o, "wb", 1'b1, 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom));
        exp_ret++;
    endtask

    initial begin
        logic [5:0] rfn[5];
        logic [5:0] op, fn;
        rfn[0] = 6'h20; rfn[1] = 6'h22; rfn[2] = 6'h24; rfn[3] = 6'h25; rfn[4] = 6'h2A;

        do_reset(2);
        // Directed cases
        run_instr(6'h00, 6'h20, 1'b0, 0, 0, -1);   // add: 0,1,2,4
        run_instr(6'h23, 6'h00, 1'b0, 0, 2, -1);   // lw, 2 MEM stalls
        run_instr(6'h04, 6'h00, 1'b1, 0, 0, -1);   // beq taken
        run_instr(6'h04, 6'h00, 1'b0, 0, 0, -1);   // beq not taken
        run_instr(6'h02, 6'h00, 1'b0, 0, 0, -1);   // j
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0, -1);   // illegal op
        run_instr(6'h00, 6'h13, 1'b0, 1, 0, -1);   // R-type, bad funct
        run_instr(6'h08, 6'h00, 1'b0, 0, 0, -1);   // fetch after illegal
        do_reset(1);                               // illegal clears

        // Five retirements, then reset during a sw MEM stall
        run_instr(6'h08, 6'h00, 1'b0, 0, 0, -1);
        run_instr(6'h00, 6'h22, 1'b0, 1, 0, -1);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 1, -1);
        run_instr(6'h00, 6'h2A, 1'b0, 0, 0, -1);
        run_instr(6'h02, 6'h00, 1'b0, 2, 0, -1);
        run_instr(6'h2B, 6'h00, 1'b0, 0, 3, 1);
        do_reset(2);

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin op = 6'h00; fn = rfn[$urandom_range(0, 4)]; end
                3:       begin op = 6'h08; fn = 6'($urandom); end
                4:       begin op = 6'h23; fn = 6'($urandom); end
                5:       begin op = 6'h2B; fn = 6'($urandom); end
                6:       begin op = 6'h04; fn = 6'($urandom); end
                7:       begin op = 6'h02; fn = 6'($urandom); end
                8:       begin op = 6'($urandom); fn = 6'($urandom); end
                default: begin op = 6'h00; fn = 6'($urandom); end
            endcase
            run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1);
            if ($urandom_range(0, 39) == 0) do_reset(1);
        end

        @(negedge clock);
        #1;
        n_chk++;
        if (expq.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending want 0", expq.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the CPU datapath: steps each instruction through FETCH, DECODE, EXEC, MEM and WB states. It drives the PC/IR write enables, memory strobes, register-file write and the 5-bit ALU opcode, and waits on a shared memory ready handshake. It replaces the free-running `pc + 4` / always-write scheme with sequenced strobes, so one memory port and one ALU can be shared across phases.

## Interface
- `CNT_W`, 32, width of retired-instruction counter
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `ir_op`  in  6  instruction[31:26] from memory read data (valid when `mem_ready` in FETCH)
- `ir_funct`  in  6  instruction[5:0], same timing as `ir_op`
- `zero`  in  1  ALU zero flag, sampled in EXEC
- `mem_ready`  in  1  memory completes the current access this cycle
- `pc_write`  out  1  PC load strobe
- `pc_src`  out  2  0 = pc+4, 1 = branch target, 2 = jump target
- `ir_write`  out  1  IR load strobe
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU result
- `mem_read`, `mem_write`  out  1 each  memory strobes
- `reg_write`  out  1  register-file write strobe
- `reg_dst`  out  1  1 = rd, 0 = rt
- `mem_to_reg`  out  1  1 = memory data, 0 = ALU result
- `alu_src_b`  out  1  1 = sign-extended imm, 0 = bus_b
- `aluop`  out  5  ADD=0, SUB=1, AND=2, OR=3, SLT=4
- `state`  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
- `illegal`  out  1  sticky unsupported-opcode flag
- `retired`  out  CNT_W  count of completed legal instructions

## Operation
- Supported instructions:
  - R-type op 0x00 with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
  - Anything else, including an R-type with an unlisted funct, is illegal.
- Internal registers: `op_q` and `funct_q`, loaded when `ir_write` fires.
- FETCH: `mem_read`=1, `iord`=0.
  - `mem_ready`=0: hold in FETCH.
  - `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0; go to DECODE.
- DECODE:
  - j: `pc_write`=1, `pc_src`=2, go to FETCH.
  - Illegal: set `illegal`, go to FETCH, PC not written.
  - Otherwise go to EXEC.
- EXEC: `aluop` per instruction (addi/lw/sw=ADD with `alu_src_b`=1; beq=SUB).
  - beq: `pc_write`=`zero`, `pc_src`=1, go to FETCH.
  - R/addi: go to WB.
  - lw/sw: go to MEM.
- MEM: `iord`=1; lw asserts `mem_read`, sw asserts `mem_write`.
  - Hold while `mem_ready`=0.
  - On ready: sw goes to FETCH, lw goes to WB.
- WB: `reg_write`=1; `reg_dst`=1 for R-type; `mem_to_reg`=1 for lw. Go to FETCH.
- Output rules:
  - Outputs are combinational from `state`, `op_q`, `funct_q`, `zero`, `mem_ready`.
  - Unlisted outputs are 0; `aluop`=ADD outside EXEC.
- `retired` increments by 1 on the final cycle of each legal instruction (the transition into FETCH) and wraps modulo 2^CNT_W.
- Illegal opcodes never increment `retired`. `illegal` clears only on reset.
- State encodings 5-7 are unreachable; if entered, go to FETCH next cycle with all strobes 0.

## Timing
- Reset low:
  - Immediately: `state`=FETCH, `op_q`=`funct_q`=0, `retired`=0, `illegal`=0.
  - While reset is low, all write/read strobes are forced to 0, including `mem_read`.
- First rising edge after reset release: FETCH with `mem_read`=1.
- Latencies with `mem_ready` held high:
  - R/addi 4 cycles, lw 5, sw 4, beq 3, j 2, illegal 2.
  - Each `mem_ready`=0 cycle in FETCH or MEM adds one cycle.
- Reset mid-instruction aborts it:
  - No partial strobes after the reset assertion.
  - `retired` is not incremented for the aborted instruction.
- `mem_ready` outside FETCH/MEM is ignored.
- `ir_op`/`ir_funct` are sampled only on the `ir_write` edge.

## Test plan
- Reset, then `mem_ready`=1, instruction add (op 0, funct 0x20):
  - States go 0,1,2,4,0.
  - `aluop`=0 in EXEC; `reg_write`=1 and `reg_dst`=1 in WB.
  - `retired`=1 after 4 cycles.
- lw with `mem_ready` low for 2 cycles in MEM:
  - MEM held 3 cycles with `iord`=1 and `mem_read`=1.
  - WB has `mem_to_reg`=1; total 7 cycles.
- beq with `zero`=1, then beq with `zero`=0:
  - `pc_write`=1, `pc_src`=1 in the first EXEC.
  - `pc_write`=0 in the second EXEC.
  - `retired` increases by 2.
- j: `pc_write`=1, `pc_src`=2 in DECODE; back in FETCH 2 cycles after the fetch.
- Op 0x3F: `illegal`=1 from the cycle after DECODE, `retired` unchanged, next fetch proceeds normally. Then assert reset: `illegal`=0.
- Assert reset during a sw MEM stall with `retired`=5: `mem_write` drops immediately, `state`=0, `retired`=0.
